pipelined_adder_tree: RTL

Parametrised, pipelined successor to the combinational masked 8x4-bit adder tree. Sums LANES unsigned DATA_W-bit lanes, each gated by a per-lane enable mask. One register per tree level, valid/ready handshake with global stall, and an optional multi-beat accumulate mode with saturating accumulator. Sits between the operand/mask generator and the datapath result consumer.

---
 rtl/adder_tree_pkg.sv | 34 +++
 rtl/adder_tree_level.sv | 47 ++++
 rtl/pipelined_adder_tree.sv | 126 ++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined masked adder tree: width arithmetic and
// the layout of the flattened inter-level sum bus.
package adder_tree_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // Width of one partial sum at tree level k (level 0 = raw lanes).
  function automatic int unsigned level_w(input int unsigned data_w, input int unsigned k);
    return data_w + k;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  // Start bit of level k inside a bus that packs levels 0..k-1 back to back.
  function automatic int unsigned bus_offset(input int unsigned lanes, input int unsigned data_w,
                                             input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) begin
      off += (lanes >> j) * level_w(data_w, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered tree level: pairwise adds IN_N partial sums into IN_N/2 sums
// one bit wider, carrying valid and accumulate side-band along with the data.
module adder_tree_level #(
  parameter int unsigned IN_N = 8,
  parameter int unsigned IN_W = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               in_valid,
  input  logic                               in_acc,
  input  logic                               in_last,
  input  logic [IN_N*IN_W-1:0]               in_sum,
  output logic                               out_valid,
  output logic                               out_acc,
  output logic                               out_last,
  output logic [(IN_N/2)*(IN_W+1)-1:0]       out_sum
);

  localparam int unsigned OUT_N = IN_N / 2;
  localparam int unsigned OUT_W = IN_W + 1;

  logic [OUT_N*OUT_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < OUT_N; i++) begin
      sum_d[i*OUT_W +: OUT_W] = OUT_W'(in_sum[(2*i)*IN_W +: IN_W])
                              + OUT_W'(in_sum[(2*i+1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= 1'b0;
      out_last  <= 1'b0;
      out_sum   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_acc   <= in_acc;
      out_last  <= in_last;
      out_sum   <= sum_d;
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined masked adder tree with valid/ready handshake, global stall and a
// saturating multi-beat accumulator in the final (output) level.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic                    in_acc,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic                    out_ovf
);

  localparam int unsigned S       = clog2(LANES);
  localparam int unsigned BUS_W   = bus_offset(LANES, DATA_W, S);
  localparam int unsigned TOP_W   = level_w(DATA_W, S - 1);
  localparam int unsigned TOP_OFF = bus_offset(LANES, DATA_W, S - 1);

  if (!is_pow2(LANES) || LANES < 2 || LANES > 64) begin : gen_bad_lanes
    $error("pipelined_adder_tree: LANES must be a power of two in 2..64");
  end
  if (ACC_W < DATA_W + S) begin : gen_bad_acc_w
    $error("pipelined_adder_tree: ACC_W must be at least DATA_W + clog2(LANES)");
  end

  logic                    en;
  logic [LANES*DATA_W-1:0] masked;
  logic [BUS_W-1:0]        lvl_sum;
  logic [S-1:0]            lvl_valid;
  logic [S-1:0]            lvl_acc;
  logic [S-1:0]            lvl_last;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Gating on in_valid as well keeps undriven data out of the tree.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      masked[i*DATA_W +: DATA_W] = (in_valid && in_mask[i]) ? in_data[i*DATA_W +: DATA_W]
                                                            : '0;
    end
  end

  assign lvl_sum[LANES*DATA_W-1:0] = masked;
  assign lvl_valid[0]              = in_valid && in_ready;
  assign lvl_acc[0]                = in_acc;
  assign lvl_last[0]               = in_last;

  for (genvar k = 1; k < S; k++) begin : gen_lvl
    localparam int unsigned IN_N = LANES >> (k - 1);
    localparam int unsigned IN_W = level_w(DATA_W, k - 1);

    adder_tree_level #(
      .IN_N (IN_N),
      .IN_W (IN_W)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (lvl_valid[k-1]),
      .in_acc    (lvl_acc[k-1]),
      .in_last   (lvl_last[k-1]),
      .in_sum    (lvl_sum[bus_offset(LANES, DATA_W, k - 1) +: IN_N*IN_W]),
      .out_valid (lvl_valid[k]),
      .out_acc   (lvl_acc[k]),
      .out_last  (lvl_last[k]),
      .out_sum   (lvl_sum[bus_offset(LANES, DATA_W, k) +: (IN_N/2)*(IN_W+1)])
    );
  end

  logic [TOP_W:0]   top_sum;
  logic [ACC_W:0]   t_ext;
  logic [ACC_W:0]   r_raw;
  logic [ACC_W-1:0] r_sat;
  logic             r_ovf;
  logic [ACC_W-1:0] acc_q;
  logic             grp_ovf_q;

  assign top_sum = (TOP_W+1)'(lvl_sum[TOP_OFF +: TOP_W])
                 + (TOP_W+1)'(lvl_sum[TOP_OFF+TOP_W +: TOP_W]);
  assign t_ext   = (ACC_W+1)'(top_sum);
  // acc < 2^ACC_W and t < 2^ACC_W, so the carry bit alone flags overflow.
  assign r_raw   = {1'b0, acc_q} + t_ext;
  assign r_ovf   = r_raw[ACC_W];
  assign r_sat   = r_ovf ? '1 : r_raw[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      acc_q     <= '0;
      grp_ovf_q <= 1'b0;
    end else if (en) begin
      out_valid <= 1'b0;
      if (lvl_valid[S-1]) begin
        if (!lvl_acc[S-1]) begin
          out_valid <= 1'b1;
          out_sum   <= t_ext[ACC_W-1:0];
          out_ovf   <= 1'b0;
        end else if (lvl_last[S-1]) begin
          out_valid <= 1'b1;
          out_sum   <= r_sat;
          out_ovf   <= grp_ovf_q | r_ovf;
          acc_q     <= '0;
          grp_ovf_q <= 1'b0;
        end else begin
          acc_q     <= r_sat;
          grp_ovf_q <= grp_ovf_q | r_ovf;
        end
      end
    end
  end

endmodule
